// File: rtl/pulse_swallow_ctrl.sv
// pulse_swallow_ctrl: modulus controller closing the mod/clk_out loop of a divide-by-3/4 prescaler
//
// Total division N = 3*P + S input cycles per output period. The first S
// prescaler cycles of each period run at /4 and the remaining P-S cycles run at /3.
//
// Build option: define DUTY_50_EN for a near-50% duty clk_out
// (high while pcnt < P/2). Without it, clk_out is a one-cycle pulse equal to period_done.
//
// Ports:
//   clk_in      in   prescaler output clock, the only clock
//   rstn        in   synchronous active-low reset
//   p_val       in   requested program count P (valid range 2..2^P_WIDTH-1)
//   s_val       in   requested swallow count S (must be <= P)
//   load        in   one-cycle strobe that samples p_val/s_val
//   mod         out  prescaler modulus select: 1 = /4, 0 = /3
//   clk_out     out  divided output clock
//   period_done out  one-cycle pulse on the last prescaler cycle of each period
//   cfg_err     out  sticky flag: the most recent load was invalid
module pulse_swallow_ctrl #(
    parameter int P_WIDTH = 6,
    parameter int S_WIDTH = 6
) (
    input  logic               clk_in,
    input  logic               rstn,
    input  logic [P_WIDTH-1:0] p_val,
    input  logic [S_WIDTH-1:0] s_val,
    input  logic               load,
    output logic               mod,
    output logic               clk_out,
    output logic               period_done,
    output logic               cfg_err
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t             state_q, state_d;
    logic [P_WIDTH-1:0] pcnt_q, pcnt_d, p_act_q, p_act_d, p_pend_q, p_pend_d;
    logic [S_WIDTH-1:0] s_act_q, s_act_d, s_pend_q, s_pend_d;
    logic               pend_vld_q, pend_vld_d, cfg_err_q, cfg_err_d;
    logic               mod_q, mod_d, clk_out_q, clk_out_d, done_q, done_d;
    logic               load_ok, wrap;
    assign load_ok = load && (p_val >= P_WIDTH'(2)) && (P_WIDTH'(s_val) <= p_val);
    assign wrap    = (state_q == RUN) && (pcnt_q == p_act_q - P_WIDTH'(1));
    always_ff @(posedge clk_in) begin
        if (!rstn) begin
            state_q    <= IDLE;
            pcnt_q     <= '0;
            p_act_q    <= '0;
            s_act_q    <= '0;
            p_pend_q   <= '0;
            s_pend_q   <= '0;
            pend_vld_q <= 1'b0;
            cfg_err_q  <= 1'b0;
            mod_q      <= 1'b0;
            clk_out_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pcnt_q     <= pcnt_d;
            p_act_q    <= p_act_d;
            s_act_q    <= s_act_d;
            p_pend_q   <= p_pend_d;
            s_pend_q   <= s_pend_d;
            pend_vld_q <= pend_vld_d;
            cfg_err_q  <= cfg_err_d;
            mod_q      <= mod_d;
            clk_out_q  <= clk_out_d;
            done_q     <= done_d;
        end
    end
    always_comb begin
        state_d    = state_q;
        pcnt_d     = pcnt_q;
        p_act_d    = p_act_q;
        s_act_d    = s_act_q;
        p_pend_d   = p_pend_q;
        s_pend_d   = s_pend_q;
        pend_vld_d = pend_vld_q;
        cfg_err_d  = load ? !load_ok : cfg_err_q;
        if (state_q == IDLE) begin
            pcnt_d = '0;
            if (load_ok) begin
                state_d = RUN;
                p_act_d = p_val;
                s_act_d = s_val;
            end
        end else if (wrap) begin
            // A load arriving on the wrap cycle beats any older pending value.
            pcnt_d     = '0;
            pend_vld_d = 1'b0;
            if (load_ok) begin
                p_act_d = p_val;
                s_act_d = s_val;
            end else if (pend_vld_q) begin
                p_act_d = p_pend_q;
                s_act_d = s_pend_q;
            end
        end else begin
            pcnt_d = pcnt_q + P_WIDTH'(1);
            if (load_ok) begin
                p_pend_d   = p_val;
                s_pend_d   = s_val;
                pend_vld_d = 1'b1;
            end
        end
        // Outputs are decoded from next state so they line up with pcnt_q.
        mod_d  = (state_d == RUN) && (pcnt_d < P_WIDTH'(s_act_d));
        done_d = (state_d == RUN) && (pcnt_d == p_act_d - P_WIDTH'(1));
`ifdef DUTY_50_EN
        clk_out_d = (state_d == RUN) && (pcnt_d < (p_act_d >> 1));
`else
        clk_out_d = done_d;
`endif
    end
    assign mod         = mod_q;
    assign clk_out     = clk_out_q;
    assign period_done = done_q;
    assign cfg_err     = cfg_err_q;
endmodule

// File: tb/tb_pulse_swallow_ctrl.sv
// tb_pulse_swallow_ctrl: randomized self-checking bench for pulse_swallow_ctrl
module tb_pulse_swallow_ctrl;
    logic       clk_in = 1'b0;
    logic       rstn, load;
    logic [5:0] p_val, s_val;
    logic       mod, clk_out, period_done, cfg_err;
    int         checks = 0;
    int         errors = 0;
    // Reference: current period config (cp/cs) and the config the next period will use (np/ns).
    bit         run, err;
    int         ph, cp, cs, np, ns, acc;

    pulse_swallow_ctrl #(.P_WIDTH(6), .S_WIDTH(6)) dut (
        .clk_in(clk_in), .rstn(rstn), .p_val(p_val), .s_val(s_val), .load(load),
        .mod(mod), .clk_out(clk_out), .period_done(period_done), .cfg_err(cfg_err)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        bit r  = rstn;
        bit l  = load;
        int pv = int'(p_val);
        int sv = int'(s_val);
        bit ok;
        @(posedge clk_in);
        #1;
        if (!r) begin
            run = 0; err = 0; ph = 0; cp = 0; cs = 0; np = 0; ns = 0; acc = 0;
        end else begin
            ok = l && pv >= 2 && sv <= pv;
            if (l) err = !ok;
            if (ok) begin np = pv; ns = sv; end
            if (!run) begin
                if (ok) begin run = 1; ph = 0; cp = np; cs = ns; end
            end else if (ph == cp - 1) begin
                ph = 0; cp = np; cs = ns;
            end else begin
                ph++;
            end
        end
        check("mod", int'(mod), int'(run && ph < cs));
        check("period_done", int'(period_done), int'(run && ph == cp - 1));
`ifdef DUTY_50_EN
        check("clk_out", int'(clk_out), int'(run && ph < cp / 2));
`else
        check("clk_out", int'(clk_out), int'(run && ph == cp - 1));
`endif
        check("cfg_err", int'(cfg_err), int'(err));
        // Prescaler model: input cycles per output period from the DUT's own mod.
        if (run) begin
            if (ph == 0) acc = 0;
            acc += mod ? 4 : 3;
            if (ph == cp - 1) check("n_div", acc, 3 * cp + cs);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic ld(input int p, input int s);
        p_val = 6'(p);
        s_val = 6'(s);
        load  = 1'b1;
        step();
        load  = 1'b0;
    endtask

    task automatic wait_ph(input int n);
        int g = 0;
        while (!(run && ph == n) && g < 100) begin
            step();
            g++;
        end
        check("wait_ph", int'(run && ph == n), 1);
    endtask

    initial begin
        rstn = 1'b0; load = 1'b0; p_val = '0; s_val = '0;
        cyc(2);
        rstn = 1'b1;
        cyc(20);
        ld(5, 2);
        cyc(16);
        ld(4, 0);
        cyc(12);
        ld(4, 4);
        cyc(12);
        ld(5, 2);
        cyc(6);
        ld(1, 0);
        cyc(3);
        ld(3, 4);
        cyc(8);
        ld(5, 2);
        cyc(3);
        wait_ph(2);
        ld(7, 3);
        cyc(14);
        wait_ph(6);
        ld(4, 1);
        cyc(10);
        ld(6, 2);
        cyc(8);
        wait_ph(3);
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        cyc(6);
        ld(6, 3);
        cyc(14);
        for (int i = 0; i < 600; i++) begin
            rstn  = ($urandom_range(99) != 0);
            load  = ($urandom_range(7) == 0);
            p_val = 6'($urandom_range(12));
            s_val = 6'($urandom_range(12));
            step();
            rstn  = 1'b1;
            load  = 1'b0;
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
